// File: rtl/rom_loader_pkg.sv
// Shared constants, FSM encoding, write-request record and parameter unpack helpers for rom_region_loader.
package rom_loader_pkg;

  localparam int IOCTL_AW = 27;
  localparam int MAX_NREG = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Stage-0 record: only the winning region is carried, so one offset/data field suffices.
  typedef struct packed {
    logic                vld;
    logic [2:0]          idx;
    logic [IOCTL_AW-1:0] ofs;
    logic [7:0]          dat;
  } wr_req_t;

  function automatic logic [IOCTL_AW-1:0] base_of(input int i, input logic [IOCTL_AW*MAX_NREG-1:0] v);
    return v[IOCTL_AW*i +: IOCTL_AW];
  endfunction

  function automatic logic [4:0] size_log2_of(input int i, input logic [5*MAX_NREG-1:0] v);
    return v[5*i +: 5];
  endfunction

  function automatic logic [7:0] xmask_of(input int i, input logic [8*MAX_NREG-1:0] v);
    return v[8*i +: 8];
  endfunction

endpackage

// File: rtl/rom_region_bank.sv
// One ROM region: single-port sync RAM (write wins the port, registered read) plus a saturating load counter.
// Read latency 1 cycle; no backpressure, writes are accepted every cycle.
module rom_region_bank #(
  parameter int DW = 8,
  parameter int AW = 17,
  parameter int SL = AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          loaded,
  output logic          loaded_nxt
);

  localparam int DEPTH = 1 << SL;

  logic [DW-1:0] mem [DEPTH];
  logic [SL:0]   count;
  logic [SL-1:0] addr;
  logic          unused_addr;

  assign addr        = we ? waddr[SL-1:0] : raddr[SL-1:0];
  assign unused_addr = ^{waddr, raddr};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)    rdata <= '0;
    else if (!we) rdata <= mem[addr];
  end

  // Counter saturates at DEPTH, so its MSB alone flags a full region.
  always_ff @(posedge clk) begin
    if (reset || clear)     count <= '0;
    else if (we && !count[SL]) count <= count + (SL+1)'(1);
  end

  assign loaded     = count[SL];
  assign loaded_nxt = count[SL] | (we & (&count[SL-1:0]));

endmodule

// File: rtl/rom_region_loader.sv
// Decodes the ioctl download stream into NREG ROM regions; 2-cycle write pipe, 1-cycle read ports.
// No backpressure: every ioctl_wr in LOAD is taken; reads return zero while a download owns the RAMs.
module rom_region_loader
  import rom_loader_pkg::*;
#(
  parameter int                         NREG      = 5,
  parameter int                         AW        = 17,
  parameter logic [IOCTL_AW*NREG-1:0]   BASE      = '0,
  parameter logic [5*NREG-1:0]          SIZE_LOG2 = {NREG{5'd17}},
  parameter logic [8*NREG-1:0]          XMASK     = '0
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [15:0]         ioctl_dout,
  input  logic                ioctl_wr,
  input  logic [NREG*AW-1:0]  rd_addr,
  output logic [NREG*8-1:0]   rd_data,
  output logic [NREG-1:0]     region_loaded,
  output logic                load_done,
  output logic                load_error,
  output logic                busy
);

  localparam logic [IOCTL_AW*MAX_NREG-1:0] BASE_X = (IOCTL_AW*MAX_NREG)'(BASE);
  localparam logic [5*MAX_NREG-1:0]        SL_X   = (5*MAX_NREG)'(SIZE_LOG2);
  localparam logic [8*MAX_NREG-1:0]        XM_X   = (8*MAX_NREG)'(XMASK);

  logic [1:0]      state;
  logic            clear;
  wr_req_t         req;
  wr_req_t         s0;
  logic [IOCTL_AW:0] diff;
  logic [NREG-1:0] loaded_nxt;
  logic [7:0]      bank_rdata [NREG];
  logic            unused_bits;

  assign unused_bits = ^{ioctl_dout[15:8], s0.ofs};

  // Scan from the top index down so the lowest-index overlapping region wins.
  always_comb begin
    req  = '0;
    diff = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      diff = {1'b0, ioctl_addr} - {1'b0, base_of(i, BASE_X)};
      if (!diff[IOCTL_AW] && ((diff[IOCTL_AW-1:0] >> size_log2_of(i, SL_X)) == '0)) begin
        req.vld = 1'b1;
        req.idx = 3'(i);
        req.ofs = diff[IOCTL_AW-1:0];
        req.dat = ioctl_dout[7:0] ^ xmask_of(i, XM_X);
      end
    end
    req.vld = req.vld & ioctl_wr & (state == ST_LOAD);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) s0 <= '0;
    else       s0 <= req;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (ioctl_download) begin
            state      <= ST_LOAD;
            load_done  <= 1'b0;
            load_error <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!ioctl_download) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // The last write lands on this edge, so judge completeness on the post-write counts.
          state      <= ST_DONE;
          load_done  <= &loaded_nxt;
          load_error <= ~&loaded_nxt;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign clear = ((state == ST_IDLE) || (state == ST_DONE)) && ioctl_download;
  assign busy  = (state == ST_LOAD) || (state == ST_FLUSH);

  for (genvar g = 0; g < NREG; g++) begin : g_bank
    rom_region_bank #(
      .DW(8),
      .AW(AW),
      .SL(int'(size_log2_of(g, SL_X)))
    ) u_bank (
      .clk       (clk_sys),
      .reset     (reset),
      .clear     (clear),
      .we        (s0.vld && (s0.idx == 3'(g))),
      .waddr     (s0.ofs[AW-1:0]),
      .wdata     (s0.dat),
      .raddr     (rd_addr[AW*g +: AW]),
      .rdata     (bank_rdata[g]),
      .loaded    (region_loaded[g]),
      .loaded_nxt(loaded_nxt[g])
    );

    assign rd_data[8*g +: 8] = busy ? 8'h00 : bank_rdata[g];
  end

endmodule

// File: tb/tb_rom_region_loader.sv
// Directed + randomized bench for rom_region_loader with a behavioural byte-array model of the regions.
module tb_rom_region_loader;

  localparam int NREG = 2;
  localparam int AW   = 9;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 ioctl_download = 1'b0;
  logic [26:0]          ioctl_addr = '0;
  logic [15:0]          ioctl_dout = '0;
  logic                 ioctl_wr = 1'b0;
  logic [NREG*AW-1:0]   rd_addr = '0;
  logic [NREG*8-1:0]    rd_data, rd_data_ov;
  logic [NREG-1:0]      region_loaded, region_loaded_ov;
  logic                 load_done, load_error, busy;
  logic                 load_done_ov, load_error_ov, busy_ov;

  int checks = 0;
  int errors = 0;

  // Model: [dut][region]; dut 0 = distinct bases, dut 1 = both bases at 0.
  int         base_m [2][2];
  logic [7:0] xm_m   [2];
  logic [7:0] mem_m  [2][2][256];
  int         cnt_m  [2][2];

  always #5 clk = ~clk;

  rom_region_loader #(
    .NREG(NREG), .AW(AW),
    .BASE({27'h100, 27'h000}),
    .SIZE_LOG2({5'd8, 5'd8}),
    .XMASK({8'hff, 8'h00})
  ) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .rd_addr(rd_addr), .rd_data(rd_data), .region_loaded(region_loaded),
    .load_done(load_done), .load_error(load_error), .busy(busy)
  );

  rom_region_loader #(
    .NREG(NREG), .AW(AW),
    .BASE({27'h000, 27'h000}),
    .SIZE_LOG2({5'd8, 5'd8}),
    .XMASK({8'hff, 8'h00})
  ) dut_ov (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .rd_addr(rd_addr), .rd_data(rd_data_ov), .region_loaded(region_loaded_ov),
    .load_done(load_done_ov), .load_error(load_error_ov), .busy(busy_ov)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_write(input int addr, input logic [7:0] data);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (addr >= base_m[d][r] && addr < base_m[d][r] + 256) begin
          mem_m[d][r][addr - base_m[d][r]] = data ^ xm_m[r];
          if (cnt_m[d][r] < 256) cnt_m[d][r]++;
          break;
        end
      end
    end
  endfunction

  function automatic void model_clear_counts();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) cnt_m[d][r] = 0;
  endfunction

  task automatic start_dl;
    ioctl_download = 1'b1;
    tick();
    model_clear_counts();
    chk("busy_in_load", 32'(busy), 32'd1);
    chk("rd_zero_in_load", 32'(rd_data), 32'd0);
  endtask

  // gap=0 keeps the strobe high so the next call makes a back-to-back write.
  task automatic wr(input int addr, input logic [7:0] data, input int gap);
    ioctl_addr = 27'(addr);
    ioctl_dout = {8'($urandom), data};
    ioctl_wr   = 1'b1;
    tick();
    model_write(addr, data);
    if (gap > 0) begin
      ioctl_wr = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic check_status(input string tag);
    logic [1:0] exp_l0, exp_l1;
    exp_l0 = {cnt_m[0][1] == 256, cnt_m[0][0] == 256};
    exp_l1 = {cnt_m[1][1] == 256, cnt_m[1][0] == 256};
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_loaded"},    32'(region_loaded), 32'(exp_l0));
    chk({tag, "_done"},      32'(load_done), 32'(&exp_l0));
    chk({tag, "_error"},     32'(load_error), 32'(~&exp_l0));
    chk({tag, "_ov_loaded"}, 32'(region_loaded_ov), 32'(exp_l1));
    chk({tag, "_ov_error"},  32'(load_error_ov), 32'(~&exp_l1));
  endtask

  task automatic end_dl(input string tag);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick();
    tick();
    check_status(tag);
  endtask

  // Random upper address bit must be ignored by the read ports.
  task automatic read_chk(input string tag, input int a);
    logic [AW-1:0] ra;
    ra = {1'($urandom), 8'(a)};
    rd_addr = {ra, ra};
    tick();
    chk({tag, "_rd0"},    32'(rd_data[7:0]),    32'(mem_m[0][0][a]));
    chk({tag, "_rd1"},    32'(rd_data[15:8]),   32'(mem_m[0][1][a]));
    chk({tag, "_ov_rd0"}, 32'(rd_data_ov[7:0]), 32'(mem_m[1][0][a]));
  endtask

  initial begin
    base_m[0][0] = 0;   base_m[0][1] = 'h100;
    base_m[1][0] = 0;   base_m[1][1] = 0;
    xm_m[0] = 8'h00;    xm_m[1] = 8'hff;
    model_clear_counts();

    tick();
    tick();
    chk("rst_loaded", 32'(region_loaded), 32'd0);
    chk("rst_done",   32'(load_done), 32'd0);
    chk("rst_error",  32'(load_error), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_rd",     32'(rd_data), 32'd0);
    reset = 1'b0;
    tick();

    // Full load, data = addr[7:0]
    start_dl();
    for (int a = 0; a < 512; a++) wr(a, 8'(a), $urandom_range(0, 1));
    end_dl("full");
    rd_addr = {9'h012, 9'h012};
    tick();
    chk("full_r0_12", 32'(rd_data[7:0]), 32'h12);
    chk("full_r1_12", 32'(rd_data[15:8]), 32'hed);
    chk("ovl_ld_r1",  32'(region_loaded_ov[1]), 32'd0);
    chk("ovl_error",  32'(load_error_ov), 32'd1);
    for (int k = 0; k < 8; k++) read_chk("full", $urandom_range(0, 255));

    // Short load: last byte of region 1 missing
    start_dl();
    for (int a = 0; a < 511; a++) wr(a, 8'($urandom), $urandom_range(0, 1));
    end_dl("short");
    chk("short_loaded", 32'(region_loaded), 32'b01);
    for (int k = 0; k < 4; k++) read_chk("short", $urandom_range(0, 255));

    // Back-to-back with the final strobe on the cycle download falls
    start_dl();
    for (int a = 0; a < 511; a++) wr(a, 8'($urandom), 0);
    ioctl_addr     = 27'h1ff;
    ioctl_dout     = 16'h003c;
    ioctl_wr       = 1'b1;
    ioctl_download = 1'b0;
    tick();
    model_write('h1ff, 8'h3c);
    ioctl_wr = 1'b0;
    tick();
    check_status("b2b");
    chk("b2b_loaded1", 32'(region_loaded[1]), 32'd1);
    read_chk("b2b_last", 'hff);
    chk("b2b_last_val", 32'(rd_data[15:8]), 32'hc3);

    // Strobe in DONE is ignored; misses during LOAD are ignored
    ioctl_addr = 27'h005;
    ioctl_dout = 16'h00a5;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    read_chk("offwin", 5);
    start_dl();
    for (int a = 0; a < 511; a++) begin
      wr(a, 8'($urandom), 0);
      if (a % 64 == 0) wr('h200 + $urandom_range(0, 4000), 8'($urandom), 0);
    end
    end_dl("miss");
    chk("miss_loaded", 32'(region_loaded), 32'b01);
    for (int k = 0; k < 6; k++) read_chk("miss", $urandom_range(0, 255));

    // Reset mid-LOAD with download held high
    start_dl();
    for (int a = 0; a < 100; a++) wr(a, 8'($urandom), 1);
    reset = 1'b1;
    tick();
    model_clear_counts();
    chk("mrst_busy",   32'(busy), 32'd0);
    chk("mrst_loaded", 32'(region_loaded), 32'd0);
    chk("mrst_done",   32'(load_done), 32'd0);
    chk("mrst_error",  32'(load_error), 32'd0);
    reset = 1'b0;
    tick();
    chk("mrst_reload_busy", 32'(busy), 32'd1);
    end_dl("mrst_empty");
    for (int k = 0; k < 6; k++) read_chk("mrst_keep", $urandom_range(0, 99));
    start_dl();
    for (int a = 0; a < 512; a++) wr(a, 8'($urandom), $urandom_range(0, 1));
    end_dl("reload");
    chk("reload_done", 32'(load_done), 32'd1);

    // Randomized downloads with scattered addresses, rewrites and misses
    for (int rnd = 0; rnd < 3; rnd++) begin
      start_dl();
      for (int n = 0; n < (rnd == 1 ? 250 : 900); n++)
        wr($urandom_range(0, 'h23f), 8'($urandom), $urandom_range(0, 1));
      end_dl("rand");
      for (int k = 0; k < 10; k++) read_chk("rand", $urandom_range(0, 255));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
